i2s_dac_tx: RTL and testbench

Serializes the 24-bit stereo samples produced by the equalizer output stage onto an I2S link to the DAC. It holds the most recent left/right sample pair delivered on the valid strobes, generates the bit clock and LR clock from the system clock, and shifts each channel out MSB-first in standard I2S format. It requests the next sample at every frame start and flags underrun and overrun so the upstream pipe can be checked against the frame rate.

---
 rtl/i2s_dac_tx.sv | 181 ++++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: holds the latest stereo 24-bit sample pair and serializes it
// onto a standard I2S link (bclk, lrck, data) derived from the system clock.
// Requests a new pair at each frame load and flags underrun/overrun.
module i2s_dac_tx #(
  parameter int unsigned bclk_div = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        l_data_valid,
  input  logic        r_data_valid,
  input  logic [23:0] l_data_in,
  input  logic [23:0] r_data_in,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_data,
  output logic        sample_req,
  output logic        underrun,
  output logic        overrun
);

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned BIT_W    = 6;
  localparam int unsigned POS_W    = 5;
  localparam int unsigned DIV_W    = (bclk_div > 2) ? $clog2(bclk_div) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(bclk_div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(63);
  localparam logic [POS_W-1:0] POS_FIRST = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(SAMPLE_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] l_hold;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] l_shift;
  logic [SAMPLE_W-1:0] r_shift;
  logic                l_pend;
  logic                r_pend;

  logic                active_c;
  logic                tc_c;
  logic                fall_c;
  logic                load_c;
  logic                swap_c;
  logic [BIT_W-1:0]    bit_nxt_c;
  logic [POS_W-1:0]    pos_c;
  logic [POS_W-1:0]    idx_c;
  logic [SAMPLE_W-1:0] src_c;
  logic                data_nxt_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus divider / frame event decode and next serial bit
  always_comb begin
    state_d    = state_q;
    active_c   = 1'b0;
    tc_c       = 1'b0;
    fall_c     = 1'b0;
    load_c     = 1'b0;
    swap_c     = 1'b0;
    bit_nxt_c  = bit_cnt + BIT_W'(1);
    pos_c      = bit_nxt_c[POS_W-1:0];
    idx_c      = POS_LAST - pos_c;
    src_c      = bit_nxt_c[BIT_W-1] ? r_shift : l_shift;
    data_nxt_c = 1'b0;

    case (state_q)
      IDLE:    if (run)  state_d = RUN;
      RUN:     if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Dropping run takes effect on the very clk it is seen low
    active_c = (state_q == RUN) && run;
    tc_c     = active_c && (div_cnt == DIV_LAST);
    fall_c   = tc_c && i2s_bclk;
    load_c   = fall_c && (bit_cnt == BIT_LAST);
    swap_c   = load_c && l_pend && r_pend;

    // Slot 0 is the I2S one-bit delay; slots past the sample width pad with 0
    if ((pos_c >= POS_FIRST) && (pos_c <= POS_LAST)) begin
      data_nxt_c = src_c[idx_c];
    end
  end

  // Bit-clock divider, slot counter and serial line outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= BIT_LAST;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b0;
      i2s_data <= 1'b0;
    end else if (!active_c) begin
      div_cnt  <= '0;
      bit_cnt  <= BIT_LAST;
      i2s_bclk <= 1'b0;
      i2s_lrck <= 1'b0;
      i2s_data <= 1'b0;
    end else begin
      if (tc_c) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_c) begin
        bit_cnt  <= bit_nxt_c;
        i2s_lrck <= bit_nxt_c[BIT_W-1];
        i2s_data <= data_nxt_c;
      end
    end
  end

  // Shift registers take a complete pending pair at frame load, else repeat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_shift <= '0;
      r_shift <= '0;
    end else if (swap_c) begin
      l_shift <= l_hold;
      r_shift <= r_hold;
    end
  end

  // Left holding stage; a strobe on the load clk stays pending for next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_hold <= '0;
      l_pend <= 1'b0;
    end else if (l_data_valid) begin
      l_hold <= l_data_in;
      l_pend <= 1'b1;
    end else if (swap_c) begin
      l_pend <= 1'b0;
    end
  end

  // Right holding stage, same rules as left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_pend <= 1'b0;
    end else if (r_data_valid) begin
      r_hold <= r_data_in;
      r_pend <= 1'b1;
    end else if (swap_c) begin
      r_pend <= 1'b0;
    end
  end

  // Single-clk status pulses for the upstream pipe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_req <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sample_req <= load_c;
      underrun   <= load_c && !(l_pend && r_pend);
      overrun    <= (l_data_valid && l_pend) || (r_data_valid && r_pend);
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: two instances (bclk_div 4 and 2) share stimulus and
// are each checked every clk against a time-based model of the I2S frame,
// plus directed checks that decode words off the serial line.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        l_valid;
  logic        r_valid;
  logic [23:0] l_in;
  logic [23:0] r_in;

  logic bclk_w [2];
  logic lrck_w [2];
  logic data_w [2];
  logic sr_w   [2];
  logic ur_w   [2];
  logic or_w   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int sr_cnt  = 0;
  int ur_cnt  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned DIV = (g == 0) ? 4 : 2;

    i2s_dac_tx #(.bclk_div(DIV)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .l_data_valid (l_valid),
      .r_data_valid (r_valid),
      .l_data_in    (l_in),
      .r_data_in    (r_in),
      .i2s_bclk     (bclk_w[g]),
      .i2s_lrck     (lrck_w[g]),
      .i2s_data     (data_w[g]),
      .sample_req   (sr_w[g]),
      .underrun     (ur_w[g]),
      .overrun      (or_w[g])
    );

    // Model: j counts clks since RUN was entered; everything follows from j
    int unsigned j     = 0;
    int unsigned b     = 0;
    int unsigned n     = 0;
    bit          m_run = 1'b0;
    bit          lp    = 1'b0;
    bit          rp    = 1'b0;
    bit          load_ok;
    logic [23:0] lh = '0, rh = '0, cl = '0, cr = '0, word;
    bit e_bclk = 0, e_lrck = 0, e_data = 0, e_sr = 0, e_ur = 0, e_or = 0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        j = 0; m_run = 0; lp = 0; rp = 0;
        lh = '0; rh = '0; cl = '0; cr = '0;
        e_bclk = 0; e_lrck = 0; e_data = 0; e_sr = 0; e_ur = 0; e_or = 0;
      end else begin
        load_ok = 0;
        e_sr = 0;
        e_ur = 0;
        e_or = (l_valid && lp) || (r_valid && rp);
        if (m_run && run) begin
          j++;
          e_bclk = ((j / DIV) % 2) == 1;
          if ((j % (2 * DIV)) == 0) begin
            b = (j / (2 * DIV) - 1) % 64;
            if (b == 0) begin
              e_sr = 1;
              if (lp && rp) begin
                cl = lh; cr = rh; load_ok = 1;
              end else begin
                e_ur = 1;
              end
            end
            e_lrck = (b >= 32);
            n = b % 32;
            word = (b >= 32) ? cr : cl;
            e_data = (n >= 1 && n <= 24) ? word[24 - n] : 1'b0;
          end
        end else begin
          j = 0; e_bclk = 0; e_lrck = 0; e_data = 0;
        end
        if (load_ok) begin lp = 0; rp = 0; end
        if (l_valid) begin lh = l_in; lp = 1; end
        if (r_valid) begin rh = r_in; rp = 1; end
        m_run = run;
      end
    end

    // Per-clk comparison of every output against the model
    always @(negedge clk) begin
      if (!reset) begin
        chk($sformatf("div%0d_bclk", DIV),  32'(bclk_w[g]), 32'(e_bclk));
        chk($sformatf("div%0d_lrck", DIV),  32'(lrck_w[g]), 32'(e_lrck));
        chk($sformatf("div%0d_data", DIV),  32'(data_w[g]), 32'(e_data));
        chk($sformatf("div%0d_sreq", DIV),  32'(sr_w[g]),   32'(e_sr));
        chk($sformatf("div%0d_under", DIV), 32'(ur_w[g]),   32'(e_ur));
        chk($sformatf("div%0d_over", DIV),  32'(or_w[g]),   32'(e_or));
      end
    end
  end

  // Pulse counters for the bclk_div = 2 instance
  always @(negedge clk) begin
    if (sr_w[1]) sr_cnt++;
    if (ur_w[1]) ur_cnt++;
  end

  task automatic strobe(input logic [23:0] a, input logic [23:0] c);
    l_in = a; r_in = c; l_valid = 1; r_valid = 1;
    @(negedge clk);
    l_valid = 0; r_valid = 0;
  endtask

  task automatic wait_sreq(input string name);
    int guard;
    guard = 0;
    while (!sr_w[1] && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk(name, 32'(sr_w[1]), 32'd1);
  endtask

  // Decode one frame off the div-2 line, starting at its next load
  task automatic capture_frame(output logic [23:0] lw, output logic [23:0] rw,
                               output bit tail_ok, output bit lr_ok);
    int   guard;
    int   k;
    logic prev;
    lw = '0; rw = '0; tail_ok = 1; lr_ok = 1;
    wait_sreq("capture_load_timeout");
    prev = bclk_w[1];
    k = 0;
    guard = 0;
    while (k < 64 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (bclk_w[1] && !prev) begin
        if (lrck_w[1] != (k >= 32)) lr_ok = 0;
        if (k >= 1 && k <= 24)       lw[24 - k] = data_w[1];
        else if (k >= 33 && k <= 56) rw[56 - k] = data_w[1];
        else if (data_w[1])          tail_ok = 0;
        k++;
      end
      prev = bclk_w[1];
    end
    chk("capture_bits_timeout", 32'(k), 32'd64);
  endtask

  task automatic chk_all_zero(input string name);
    for (int g = 0; g < 2; g++) begin
      chk({name, "_bclk"}, 32'(bclk_w[g]), 32'd0);
      chk({name, "_lrck"}, 32'(lrck_w[g]), 32'd0);
      chk({name, "_data"}, 32'(data_w[g]), 32'd0);
      chk({name, "_sreq"}, 32'(sr_w[g]),   32'd0);
      chk({name, "_under"}, 32'(ur_w[g]),  32'd0);
      chk({name, "_over"}, 32'(or_w[g]),   32'd0);
    end
  endtask

  initial begin
    logic [23:0] lw, rw;
    bit          tail_ok, lr_ok;
    int          sr0, ur0, low_left;

    reset = 1; run = 0; l_valid = 0; r_valid = 0; l_in = '0; r_in = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 0;
    repeat (3) @(negedge clk);

    // Data, then underrun repeats of the same pair
    strobe(24'hA55AC3, 24'h123456);
    repeat (2) @(negedge clk);
    sr0 = sr_cnt; ur0 = ur_cnt;
    run = 1;
    for (int f = 0; f < 3; f++) begin
      capture_frame(lw, rw, tail_ok, lr_ok);
      chk($sformatf("f%0d_left", f),  32'(lw), 32'h00A55AC3);
      chk($sformatf("f%0d_right", f), 32'(rw), 32'h00123456);
      chk($sformatf("f%0d_tail", f),  32'(tail_ok), 32'd1);
      chk($sformatf("f%0d_lrck", f),  32'(lr_ok), 32'd1);
    end
    chk("sreq_count", 32'(sr_cnt - sr0), 32'd3);
    chk("under_count", 32'(ur_cnt - ur0), 32'd2);

    // Overrun: two pairs in one frame, the second wins
    wait_sreq("ovr_load_timeout");
    repeat (5) @(negedge clk);
    strobe(24'h000001, 24'h000001);
    chk("over_first_pair", 32'(or_w[1]), 32'd0);
    repeat (5) @(negedge clk);
    strobe(24'h7FFFFF, 24'h7FFFFF);
    chk("over_second_pair", 32'(or_w[1]), 32'd1);
    @(negedge clk);
    chk("over_single_pulse", 32'(or_w[1]), 32'd0);
    ur0 = ur_cnt;
    capture_frame(lw, rw, tail_ok, lr_ok);
    chk("ovr_left", 32'(lw), 32'h007FFFFF);
    chk("ovr_right", 32'(rw), 32'h007FFFFF);
    chk("ovr_no_under", 32'(ur_cnt - ur0), 32'd0);

    // Stop mid-frame in the right half, then restart from the load point
    wait_sreq("stop_load_timeout");
    repeat (150) @(negedge clk);
    chk("stop_pre_lrck", 32'(lrck_w[1]), 32'd1);
    run = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("stop_bclk", 32'(bclk_w[g]), 32'd0);
      chk("stop_lrck", 32'(lrck_w[g]), 32'd0);
      chk("stop_data", 32'(data_w[g]), 32'd0);
    end
    repeat (3) @(negedge clk);
    run = 1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("restart_sreq_early", 32'(sr_w[1]), 32'd0);
        l_in = 24'h800001; r_in = 24'h00FF00; l_valid = 1; r_valid = 1;
      end
      if (i == 5) begin
        l_valid = 0; r_valid = 0;
        chk("restart_sreq", 32'(sr_w[1]), 32'd1);
        chk("restart_under", 32'(ur_w[1]), 32'd1);
      end
    end
    @(negedge clk);
    ur0 = ur_cnt;
    capture_frame(lw, rw, tail_ok, lr_ok);
    chk("coincide_left", 32'(lw), 32'h00800001);
    chk("coincide_right", 32'(rw), 32'h0000FF00);
    chk("coincide_no_under", 32'(ur_cnt - ur0), 32'd0);

    // Random strobes and occasional run drops, checked by the model
    low_left = 0;
    for (int c = 0; c < 4000; c++) begin
      l_valid = ($urandom_range(0, 99) < 3);
      r_valid = ($urandom_range(0, 99) < 3);
      l_in = 24'($urandom);
      r_in = 24'($urandom);
      if (low_left > 0) begin
        low_left--;
        run = (low_left == 0);
      end else if ($urandom_range(0, 999) < 3) begin
        run = 0;
        low_left = $urandom_range(1, 20);
      end
      @(negedge clk);
    end
    l_valid = 0; r_valid = 0; run = 1;

    // Asynchronous reset mid-frame, then restart timing at bclk_div = 4
    repeat (37) @(negedge clk);
    #1 reset = 1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 0; run = 1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 4) chk("rst_bclk_before", 32'(bclk_w[0]), 32'd0);
      if (i == 5) chk("rst_bclk_rise", 32'(bclk_w[0]), 32'd1);
      if (i == 8) chk("rst_sreq_before", 32'(sr_w[0]), 32'd0);
      if (i == 9) begin
        chk("rst_sreq", 32'(sr_w[0]), 32'd1);
        chk("rst_under", 32'(ur_w[0]), 32'd1);
      end
    end
    repeat (600) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
